// File: rtl/uvma_tcounter_mc_pkg.sv
// ============================================================================
// Module  : uvma_tcounter_mc_pkg
// Brief   : Shared types and default sizing for the multi-channel
//           timer/counter checker.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package uvma_tcounter_mc_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CNT_W  = 32;
  localparam int DEF_ERR_W  = 16;

  typedef enum logic [1:0] {
    CH_IDLE    = 2'd0,
    CH_RUNNING = 2'd1,
    CH_HALTED  = 2'd2
  } ch_state_e;

endpackage

`default_nettype wire

// File: rtl/uvma_tcounter_mc_chkr_ch.sv
// ============================================================================
// Module  : uvma_tcounter_mc_chkr_ch
// Brief   : One checker channel: shadow counter model, expected irq and
//           sticky mismatch flags against the observed DUT channel.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module uvma_tcounter_mc_chkr_ch
  import uvma_tcounter_mc_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_chk_en,
  input  logic             i_clr_err,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic [CNT_W-1:0] i_cmp,
  input  logic             i_oneshot,
  input  logic [CNT_W-1:0] i_dut_cnt,
  input  logic             i_dut_irq,
  output logic [CNT_W-1:0] o_exp_cnt,
  output logic             o_err_cnt,
  output logic             o_err_irq,
  output logic             o_mis_cnt,
  output logic             o_mis_irq
);

  ch_state_e        r_state;
  ch_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_shadow;
  logic [CNT_W-1:0] w_shadow_nxt;
  logic             r_armed;
  logic             w_armed_nxt;
  logic             r_irq;
  logic             w_irq_nxt;
  logic             r_err_cnt;
  logic             r_err_irq;
  logic             w_match;
  logic             w_mis_cnt;
  logic             w_mis_irq;

  assign w_match = (r_state == CH_RUNNING) && (r_shadow == i_cmp);

  // A compare match outranks ch_en; only a load can override it.
  always_comb begin
    w_state_nxt  = r_state;
    w_shadow_nxt = r_shadow;
    w_armed_nxt  = r_armed;
    w_irq_nxt    = 1'b0;
    if (i_load) begin
      w_shadow_nxt = i_load_val;
      w_armed_nxt  = 1'b1;
      w_state_nxt  = i_en ? CH_RUNNING : CH_IDLE;
    end else begin
      case (r_state)
        CH_IDLE: begin
          if (i_en) begin
            w_state_nxt = CH_RUNNING;
          end
        end
        CH_RUNNING: begin
          if (w_match) begin
            w_irq_nxt = 1'b1;
            if (i_oneshot) begin
              w_state_nxt = CH_HALTED;
            end else begin
              w_shadow_nxt = '0;
            end
          end else if (i_en) begin
            w_shadow_nxt = r_shadow + CNT_W'(1);
          end else begin
            w_state_nxt = CH_IDLE;
          end
        end
        CH_HALTED: begin
          w_state_nxt = CH_HALTED;
        end
        default: begin
          w_state_nxt = CH_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= CH_IDLE;
      r_shadow <= '0;
      r_armed  <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_shadow <= w_shadow_nxt;
      r_armed  <= w_armed_nxt;
      r_irq    <= w_irq_nxt;
    end
  end

  // Observations are compared against the registered model of the same cycle.
  assign w_mis_cnt = i_chk_en && r_armed && (i_dut_cnt != r_shadow);
  assign w_mis_irq = i_chk_en && r_armed && (i_dut_irq != r_irq);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err_cnt <= 1'b0;
      r_err_irq <= 1'b0;
    end else if (i_clr_err) begin
      r_err_cnt <= w_mis_cnt;
      r_err_irq <= w_mis_irq;
    end else begin
      r_err_cnt <= r_err_cnt | w_mis_cnt;
      r_err_irq <= r_err_irq | w_mis_irq;
    end
  end

  assign o_exp_cnt = r_shadow;
  assign o_err_cnt = r_err_cnt;
  assign o_err_irq = r_err_irq;
  assign o_mis_cnt = w_mis_cnt;
  assign o_mis_irq = w_mis_irq;

endmodule

`default_nettype wire

// File: rtl/uvma_tcounter_mc_chkr.sv
// ============================================================================
// Module  : uvma_tcounter_mc_chkr
// Brief   : Multi-channel timer/counter checker; per-channel shadow models
//           plus a saturating total of all mismatch events.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module uvma_tcounter_mc_chkr
  import uvma_tcounter_mc_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int ERR_W  = DEF_ERR_W
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    chk_en,
  input  logic                    clr_err,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH-1:0]       ch_load,
  input  logic [NUM_CH*CNT_W-1:0] ch_load_val,
  input  logic [NUM_CH*CNT_W-1:0] ch_cmp,
  input  logic [NUM_CH-1:0]       ch_oneshot,
  input  logic [NUM_CH*CNT_W-1:0] dut_cnt,
  input  logic [NUM_CH-1:0]       dut_irq,
  output logic [NUM_CH*CNT_W-1:0] exp_cnt,
  output logic [NUM_CH-1:0]       err_cnt,
  output logic [NUM_CH-1:0]       err_irq,
  output logic [ERR_W-1:0]        err_total
);

  localparam int              C_EVT_W   = $clog2(2 * NUM_CH + 1);
  localparam int              C_SUM_W   = ERR_W + C_EVT_W + 1;
  localparam logic [ERR_W-1:0] C_ERR_MAX = '1;

  logic [NUM_CH-1:0]  w_mis_cnt;
  logic [NUM_CH-1:0]  w_mis_irq;
  logic [C_EVT_W-1:0] w_evt_cnt;
  logic [C_SUM_W-1:0] w_sum;
  logic [ERR_W-1:0]   w_total_nxt;
  logic [ERR_W-1:0]   r_err_total;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    uvma_tcounter_mc_chkr_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_chk_en   (chk_en),
      .i_clr_err  (clr_err),
      .i_en       (ch_en[g]),
      .i_load     (ch_load[g]),
      .i_load_val (ch_load_val[g*CNT_W +: CNT_W]),
      .i_cmp      (ch_cmp[g*CNT_W +: CNT_W]),
      .i_oneshot  (ch_oneshot[g]),
      .i_dut_cnt  (dut_cnt[g*CNT_W +: CNT_W]),
      .i_dut_irq  (dut_irq[g]),
      .o_exp_cnt  (exp_cnt[g*CNT_W +: CNT_W]),
      .o_err_cnt  (err_cnt[g]),
      .o_err_irq  (err_irq[g]),
      .o_mis_cnt  (w_mis_cnt[g]),
      .o_mis_irq  (w_mis_irq[g])
    );
  end

  always_comb begin
    w_evt_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_evt_cnt = w_evt_cnt + C_EVT_W'(w_mis_cnt[i]) + C_EVT_W'(w_mis_irq[i]);
    end
  end

  // A clear restarts the total from this cycle's events so none are lost.
  always_comb begin
    w_sum = (clr_err ? '0 : C_SUM_W'(r_err_total)) + C_SUM_W'(w_evt_cnt);
    if (w_sum > C_SUM_W'(C_ERR_MAX)) begin
      w_total_nxt = C_ERR_MAX;
    end else begin
      w_total_nxt = w_sum[ERR_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err_total <= '0;
    end else begin
      r_err_total <= w_total_nxt;
    end
  end

  assign err_total = r_err_total;

endmodule

`default_nettype wire

// File: tb/tb_uvma_tcounter_mc_chkr.sv
// ============================================================================
// Module  : tb_uvma_tcounter_mc_chkr
// Brief   : Directed and randomized checks of the counter checker against a
//           behavioural channel model.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uvma_tcounter_mc_chkr;

  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int EW  = 4;
  localparam int EMAX = (1 << EW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic              chk_en;
  logic              clr_err;
  logic [NCH-1:0]    ch_en;
  logic [NCH-1:0]    ch_load;
  logic [NCH*CW-1:0] ch_load_val;
  logic [NCH*CW-1:0] ch_cmp;
  logic [NCH-1:0]    ch_oneshot;
  logic [NCH*CW-1:0] dut_cnt;
  logic [NCH-1:0]    dut_irq;
  logic [NCH*CW-1:0] exp_cnt;
  logic [NCH-1:0]    err_cnt;
  logic [NCH-1:0]    err_irq;
  logic [EW-1:0]     err_total;

  uvma_tcounter_mc_chkr #(
    .NUM_CH (NCH),
    .CNT_W  (CW),
    .ERR_W  (EW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .chk_en      (chk_en),
    .clr_err     (clr_err),
    .ch_en       (ch_en),
    .ch_load     (ch_load),
    .ch_load_val (ch_load_val),
    .ch_cmp      (ch_cmp),
    .ch_oneshot  (ch_oneshot),
    .dut_cnt     (dut_cnt),
    .dut_irq     (dut_irq),
    .exp_cnt     (exp_cnt),
    .err_cnt     (err_cnt),
    .err_irq     (err_irq),
    .err_total   (err_total)
  );

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  // Reference model: counter value, run/halt flags, armed, irq pulse, sticky flags.
  int m_cnt [NCH];
  bit m_run [NCH];
  bit m_halt[NCH];
  bit m_arm [NCH];
  bit m_irq [NCH];
  bit m_ec  [NCH];
  bit m_ei  [NCH];
  int m_total;

  int seq_a[8] = '{10, 11, 12, 13, 0, 1, 2, 3};
  int seq_b[8] = '{10, 11, 12, 13, 13, 13, 13, 13};
  int seq_c[9] = '{254, 255, 0, 1, 2, 3, 4, 5, 0};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int lane(input logic [NCH*CW-1:0] v, input int i);
    logic [CW-1:0] t;
    t = v[i*CW +: CW];
    return int'(t);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_cnt[i] = 0; m_run[i] = 0; m_halt[i] = 0; m_arm[i] = 0;
      m_irq[i] = 0; m_ec[i] = 0; m_ei[i] = 0;
    end
    m_total = 0;
  endtask

  task automatic model_edge();
    int ev;
    ev = 0;
    for (int i = 0; i < NCH; i++) begin
      bit mc;
      bit mi;
      int cmp;
      mc  = chk_en && m_arm[i] && (lane(dut_cnt, i) != m_cnt[i]);
      mi  = chk_en && m_arm[i] && (dut_irq[i] != m_irq[i]);
      ev += int'(mc) + int'(mi);
      m_ec[i] = clr_err ? mc : (m_ec[i] | mc);
      m_ei[i] = clr_err ? mi : (m_ei[i] | mi);
      cmp = lane(ch_cmp, i);
      if (ch_load[i]) begin
        m_cnt[i] = lane(ch_load_val, i);
        m_arm[i] = 1; m_run[i] = ch_en[i]; m_halt[i] = 0; m_irq[i] = 0;
      end else if (m_run[i] && m_cnt[i] == cmp) begin
        m_irq[i] = 1;
        if (ch_oneshot[i]) begin
          m_run[i] = 0; m_halt[i] = 1;
        end else begin
          m_cnt[i] = 0;
        end
      end else begin
        m_irq[i] = 0;
        if (!m_halt[i]) begin
          if (m_run[i] && ch_en[i]) m_cnt[i] = (m_cnt[i] + 1) % (1 << CW);
          else m_run[i] = ch_en[i];
        end
      end
    end
    m_total = clr_err ? ev : m_total + ev;
    if (m_total > EMAX) m_total = EMAX;
  endtask

  task automatic tick();
    logic [NCH*CW-1:0] e_cnt;
    logic [NCH-1:0]    e_ec;
    logic [NCH-1:0]    e_ei;
    model_edge();
    @(posedge clk);
    #1;
    for (int i = 0; i < NCH; i++) begin
      e_cnt[i*CW +: CW] = CW'(m_cnt[i]);
      e_ec[i] = m_ec[i];
      e_ei[i] = m_ei[i];
    end
    check("exp_cnt", 64'(exp_cnt), 64'(e_cnt));
    check("err_cnt", 64'(err_cnt), 64'(e_ec));
    check("err_irq", 64'(err_irq), 64'(e_ei));
    check("err_total", 64'(err_total), 64'(m_total));
  endtask

  task automatic follow();
    for (int i = 0; i < NCH; i++) begin
      dut_cnt[i*CW +: CW] = CW'(m_cnt[i]);
      dut_irq[i] = m_irq[i];
    end
  endtask

  initial begin
    reset_n = 1'b1; chk_en = 1'b0; clr_err = 1'b0;
    ch_en = '0; ch_load = '0; ch_load_val = '0; ch_cmp = '1;
    ch_oneshot = '0; dut_cnt = '0; dut_irq = '0;
    model_reset();
    #1 reset_n = 1'b0;
    #1;
    check("rst_exp_cnt", 64'(exp_cnt), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    check("rst_err_irq", 64'(err_irq), 64'd0);
    check("rst_err_total", 64'(err_total), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // Continuous mode: 10..13 then irq with count 0.
    ch_cmp[7:0] = 8'd13; ch_en[0] = 1'b1; ch_load[0] = 1'b1; ch_load_val[7:0] = 8'd10;
    follow(); tick(); ch_load = '0;
    for (int k = 0; k < 8; k++) begin
      check("cont_seq", 64'(exp_cnt[7:0]), 64'(seq_a[k]));
      follow();
      dut_cnt[7:0] = CW'(seq_a[k]);
      dut_irq[0]   = (k == 4);
      tick();
    end
    check("cont_irq_timing", 64'(err_irq), 64'd0);

    // One-shot mode: single irq then hold at 13; ch_en toggles do not restart.
    ch_cmp[15:8] = 8'd13; ch_oneshot[1] = 1'b1; ch_en[1] = 1'b1;
    ch_load[1] = 1'b1; ch_load_val[15:8] = 8'd10;
    follow(); tick(); ch_load = '0;
    for (int k = 0; k < 8; k++) begin
      check("oneshot_seq", 64'(exp_cnt[15:8]), 64'(seq_b[k]));
      ch_en[1] = (k != 5);
      follow();
      dut_cnt[15:8] = CW'(seq_b[k]);
      dut_irq[1]    = (k == 4);
      tick();
    end
    check("oneshot_irq_once", 64'(err_irq), 64'd0);
    ch_load[1] = 1'b1; ch_load_val[15:8] = 8'd50;
    follow(); tick(); ch_load = '0;
    follow(); tick();
    check("oneshot_reload", 64'(exp_cnt[15:8]), 64'd51);

    // Wrap through all-ones without irq; irq only after reaching 5.
    ch_cmp[23:16] = 8'h05; ch_en[2] = 1'b1; ch_load[2] = 1'b1; ch_load_val[23:16] = 8'hFE;
    follow(); tick(); ch_load = '0;
    for (int k = 0; k < 9; k++) begin
      check("wrap_seq", 64'(exp_cnt[23:16]), 64'(seq_c[k]));
      follow();
      dut_cnt[23:16] = CW'(seq_c[k]);
      dut_irq[2]     = (k == 8);
      tick();
    end
    check("wrap_no_irq", 64'(err_irq), 64'd0);

    // Mismatch beats a same-cycle clear.
    ch_cmp[31:24] = 8'd250; ch_en[3] = 1'b1; ch_load[3] = 1'b1; ch_load_val[31:24] = 8'd200;
    follow(); tick(); ch_load = '0;
    follow(); dut_irq[1] = ~dut_irq[1]; tick();
    check("pre_clr_err_irq", 64'(err_irq), 64'b0010);
    check("pre_clr_total", 64'(err_total), 64'd1);
    follow();
    dut_cnt[7:0]   = dut_cnt[7:0] + 8'd1;
    dut_cnt[23:16] = dut_cnt[23:16] + 8'd1;
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("clr_race_err_cnt", 64'(err_cnt), 64'b0101);
    check("clr_race_err_irq", 64'(err_irq), 64'd0);
    check("clr_race_total", 64'(err_total), 64'd2);

    // Persistent mismatches on every channel saturate the total.
    for (int k = 0; k < 4; k++) begin
      follow();
      for (int i = 0; i < NCH; i++) dut_cnt[i*CW +: CW] = dut_cnt[i*CW +: CW] + 8'd1;
      dut_irq = ~dut_irq;
      tick();
    end
    check("sat_total", 64'(err_total), 64'd15);
    follow(); clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("sat_cleared", 64'(err_total), 64'd0);

    // Reset mid-count abandons state; nothing flagged until reloaded.
    ch_cmp[7:0] = 8'd200; ch_oneshot[0] = 1'b0; ch_en[0] = 1'b1;
    ch_load[0] = 1'b1; ch_load_val[7:0] = 8'd100;
    follow(); tick(); ch_load = '0;
    check("pre_rst_count", 64'(exp_cnt[7:0]), 64'd100);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_exp_cnt", 64'(exp_cnt), 64'd0);
    check("mid_rst_err_total", 64'(err_total), 64'd0);
    @(posedge clk); #1;
    check("mid_rst_hold", 64'({exp_cnt, err_cnt, err_irq, err_total}), 64'd0);
    reset_n = 1'b1;
    dut_cnt = 32'hDEAD_BEEF; dut_irq = '1;
    for (int k = 0; k < 5; k++) tick();
    check("unarmed_no_err", 64'({err_cnt, err_irq, err_total}), 64'd0);
    ch_load[0] = 1'b1; ch_load_val[7:0] = 8'd7;
    tick(); ch_load = '0;
    tick();
    check("rearmed_err", 64'(err_cnt[0]), 64'd1);

    // Randomized traffic against the model.
    follow(); clr_err = 1'b1; tick(); clr_err = 1'b0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NCH; i++) begin
        ch_load[i] = ($urandom_range(15) == 0);
        ch_load_val[i*CW +: CW] = ($urandom_range(3) == 0) ? CW'(8'hF0 + $urandom_range(15))
                                                             : CW'($urandom_range(30));
        ch_en[i] = ($urandom_range(7) != 0);
        if ($urandom_range(31) == 0) ch_cmp[i*CW +: CW] = CW'($urandom_range(30));
        if ($urandom_range(31) == 0) ch_oneshot[i] = ~ch_oneshot[i];
      end
      chk_en  = ($urandom_range(15) != 0);
      clr_err = ($urandom_range(19) == 0);
      follow();
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(24) == 0)
          dut_cnt[i*CW +: CW] = dut_cnt[i*CW +: CW] + CW'($urandom_range(1, 255));
        if ($urandom_range(24) == 0) dut_irq[i] = ~dut_irq[i];
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
